// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared encodings for the MEM->WB boundary and load alignment.
package mem_wb_pkg;
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_LOAD  = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;
    localparam logic [1:0] WD_AUIPC = 2'b11;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam int PC_INC = 4;
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the byte/half/word at a byte offset and sign- or zero-extends it.
module load_align
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [OW-1:0]   offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);
    localparam logic [OW-1:0] H_MASK = ~OW'(1);
    localparam logic [OW-1:0] W_MASK = ~OW'(3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    always_comb begin
        b = 8'(rdata >> {offset, 3'b000});
        h = 16'(rdata >> {offset & H_MASK, 3'b000});
        w = 32'(rdata >> {offset & W_MASK, 3'b000});
        case (funct3)
            F3_LB:   ext = XLEN'($signed(b));
            F3_LBU:  ext = XLEN'(b);
            F3_LH:   ext = XLEN'($signed(h));
            F3_LHU:  ext = XLEN'(h);
            F3_LW:   ext = XLEN'($signed(w));
            F3_LWU:  ext = XLEN'(w);
            F3_LD:   ext = (XLEN == 64) ? rdata : XLEN'($signed(w));
            default: ext = rdata;
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: registered MEM->WB boundary with stall/flush, load extension and retire counter.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int RET_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_valid_i,
    input  logic [31:0]       mem_inst_i,
    input  logic [1:0]        mem_wd_sel_i,
    input  logic              mem_rf_we_i,
    input  logic [XLEN-1:0]   mem_alu_c_i,
    input  logic [XLEN-1:0]   mem_auipc_i,
    input  logic [XLEN-1:0]   mem_pc_i,
    input  logic [XLEN-1:0]   mem_ram_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_rf_we_o,
    output logic [REG_AW-1:0] wb_wr_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [XLEN-1:0]   wb_pc_o,
    output logic [RET_W-1:0]  retire_cnt_o
);
    localparam int OW = $clog2(XLEN / 8);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("mem_wb_stage: XLEN must be 32 or 64");
    end
    logic [4:0]      rd;
    logic [XLEN-1:0] ld, wd;
    logic            unused_inst;
    assign rd          = mem_inst_i[11:7];
    assign unused_inst = ^{mem_inst_i[31:15], mem_inst_i[6:0]};
    load_align #(.XLEN(XLEN), .OW(OW)) u_align (
        .rdata  (mem_ram_rdata_i),
        .offset (mem_alu_c_i[OW-1:0]),
        .funct3 (mem_inst_i[14:12]),
        .ext    (ld)
    );
    always_comb
        wd = mem_wd_sel_i == WD_ALU  ? mem_alu_c_i :
             mem_wd_sel_i == WD_LOAD ? ld :
             mem_wd_sel_i == WD_PC4  ? mem_pc_i + XLEN'(PC_INC) : mem_auipc_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o   <= 1'b0;
            wb_rf_we_o   <= 1'b0;
            wb_wr_o      <= '0;
            wb_data_o    <= '0;
            wb_pc_o      <= '0;
            retire_cnt_o <= '0;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
            wb_rf_we_o <= 1'b0;
            wb_wr_o    <= '0;
            wb_data_o  <= '0;
            wb_pc_o    <= '0;
        end else if (!stall_i) begin
            wb_valid_o   <= mem_valid_i;
            wb_rf_we_o   <= mem_rf_we_i & mem_valid_i & (rd != 5'd0);
            wb_wr_o      <= REG_AW'(rd);
            wb_data_o    <= wd;
            wb_pc_o      <= mem_pc_i;
            retire_cnt_o <= retire_cnt_o + RET_W'(mem_valid_i);
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: 32-bit (4-bit counter) and 64-bit instances checked against a reference model.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, stall, flush, valid, we;
    logic [31:0] inst;
    logic [1:0]  sel;
    logic [63:0] alu, auipc, pc, rdata;
    logic        v32, we32, v64, we64;
    logic [4:0]  wr32, wr64;
    logic [31:0] d32, pc32, c64;
    logic [3:0]  c32;
    logic [63:0] d64, pc64;
    int n_cmp = 0, n_bad = 0;
    logic        m_v, m_we;
    logic [4:0]  m_wr;
    logic [63:0] m_d [2];
    logic [63:0] m_pc [2];
    int unsigned m_cnt;

    mem_wb_stage #(.XLEN(32), .REG_AW(5), .RET_W(4)) u32 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .mem_valid_i(valid),
        .mem_inst_i(inst), .mem_wd_sel_i(sel), .mem_rf_we_i(we), .mem_alu_c_i(alu[31:0]),
        .mem_auipc_i(auipc[31:0]), .mem_pc_i(pc[31:0]), .mem_ram_rdata_i(rdata[31:0]),
        .wb_valid_o(v32), .wb_rf_we_o(we32), .wb_wr_o(wr32), .wb_data_o(d32),
        .wb_pc_o(pc32), .retire_cnt_o(c32));
    mem_wb_stage #(.XLEN(64), .REG_AW(5), .RET_W(32)) u64 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .mem_valid_i(valid),
        .mem_inst_i(inst), .mem_wd_sel_i(sel), .mem_rf_we_i(we), .mem_alu_c_i(alu),
        .mem_auipc_i(auipc), .mem_pc_i(pc), .mem_ram_rdata_i(rdata),
        .wb_valid_o(v64), .wb_rf_we_o(we64), .wb_wr_o(wr64), .wb_data_o(d64),
        .wb_pc_o(pc64), .retire_cnt_o(c64));

    function automatic logic [63:0] xmask(int xlen);
        return xlen == 32 ? 64'hFFFF_FFFF : '1;
    endfunction

    function automatic logic [63:0] ext(logic [63:0] v, int bits, bit sgn, int xlen);
        logic [63:0] m = (bits >= 64) ? '1 : (64'd1 << bits) - 64'd1;
        logic [63:0] r = v & m;
        if (sgn && r[bits-1]) r = r | ~m;
        return r & xmask(xlen);
    endfunction

    function automatic logic [63:0] ref_load(int xlen, logic [63:0] raw, int off, logic [2:0] f3);
        logic [63:0] r = raw & xmask(xlen);
        case (f3)
            3'd0: return ext(r >> (8 * off), 8, 1, xlen);
            3'd4: return ext(r >> (8 * off), 8, 0, xlen);
            3'd1: return ext(r >> (8 * (off & ~1)), 16, 1, xlen);
            3'd5: return ext(r >> (8 * (off & ~1)), 16, 0, xlen);
            3'd2: return ext(r >> (8 * (off & ~3)), 32, 1, xlen);
            3'd6: return ext(r >> (8 * (off & ~3)), 32, 0, xlen);
            3'd3: return xlen == 64 ? r : ext(r, 32, 1, xlen);
            default: return r;
        endcase
    endfunction

    function automatic logic [63:0] ref_wd(int xlen);
        int off = int'(alu[2:0]) % (xlen / 8);
        case (sel)
            2'd0: return alu & xmask(xlen);
            2'd1: return ref_load(xlen, rdata, off, inst[14:12]);
            2'd2: return (pc + 64'd4) & xmask(xlen);
            default: return auipc & xmask(xlen);
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        if (rst) begin
            {m_v, m_we, m_wr} = '0;
            m_d = '{64'd0, 64'd0};
            m_pc = '{64'd0, 64'd0};
            m_cnt = 0;
        end else if (flush) begin
            {m_v, m_we, m_wr} = '0;
            m_d = '{64'd0, 64'd0};
            m_pc = '{64'd0, 64'd0};
        end else if (!stall) begin
            m_v  = valid;
            m_wr = inst[11:7];
            m_we = we && valid && m_wr != 0;
            m_d  = '{ref_wd(32), ref_wd(64)};
            m_pc = '{pc & xmask(32), pc};
            if (valid) m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("v32", 64'(v32), 64'(m_v));
        chk("we32", 64'(we32), 64'(m_we));
        chk("wr32", 64'(wr32), 64'(m_wr));
        chk("d32", 64'(d32), m_d[0]);
        chk("pc32", 64'(pc32), m_pc[0]);
        chk("cnt32", 64'(c32), 64'(m_cnt % 16));
        chk("v64", 64'(v64), 64'(m_v));
        chk("we64", 64'(we64), 64'(m_we));
        chk("wr64", 64'(wr64), 64'(m_wr));
        chk("d64", d64, m_d[1]);
        chk("pc64", pc64, m_pc[1]);
        chk("cnt64", 64'(c64), 64'(m_cnt));
    endtask

    task automatic rnd_in();
        inst  = $urandom;
        sel   = 2'($urandom);
        we    = 1'($urandom);
        valid = $urandom_range(3) != 0;
        alu   = {$urandom, $urandom};
        auipc = {$urandom, $urandom};
        pc    = {$urandom, $urandom};
        rdata = {$urandom, $urandom};
    endtask

    task automatic ld(logic [2:0] f3, int off);
        {stall, flush, valid, we, sel} = {1'b0, 1'b0, 1'b1, 1'b1, 2'b01};
        inst = {17'd0, f3, 5'd3, 7'h03};
        alu  = 64'(off);
        cyc();
    endtask

    initial begin
        {rst, stall, flush} = 3'b111;
        rnd_in();
        cyc();
        rnd_in();
        cyc();
        chk("rst_d32", 64'(d32), 64'd0);
        chk("rst_cnt64", 64'(c64), 64'd0);
        {rst, stall, flush, valid, we, sel} = {3'b000, 1'b1, 1'b1, 2'b00};
        inst = 32'd5 << 7;
        alu  = 64'h1234;
        cyc();
        chk("alu_d32", 64'(d32), 64'h1234);
        chk("alu_we32", 64'(we32), 64'd1);
        chk("alu_cnt32", 64'(c32), 64'd1);
        rdata = 64'h80FF_7F01;
        ld(3'd0, 3); chk("lb", 64'(d32), 64'hFFFF_FF80);
        ld(3'd4, 1); chk("lbu", 64'(d32), 64'h0000_007F);
        ld(3'd1, 2); chk("lh", 64'(d32), 64'hFFFF_80FF);
        ld(3'd5, 3); chk("lhu", 64'(d32), 64'h0000_80FF);
        ld(3'd2, 0); chk("lw", 64'(d32), 64'h80FF_7F01);
        ld(3'd7, 2); chk("raw", 64'(d32), 64'h80FF_7F01);
        for (int i = 0; i < 3; i++) begin
            rnd_in();
            stall = 1'b1;
            cyc();
            chk("stall_d32", 64'(d32), 64'h80FF_7F01);
        end
        chk("stall_cnt32", 64'(c32), 64'd7);
        rnd_in();
        {stall, flush, valid} = 3'b111;
        cyc();
        chk("flush_v32", 64'(v32), 64'd0);
        chk("flush_d64", d64, 64'd0);
        {stall, flush, valid, we, sel} = {3'b001, 1'b1, 2'b00};
        inst = 32'h0000_0033;
        alu  = 64'hABCD;
        cyc();
        chk("x0_we32", 64'(we32), 64'd0);
        chk("x0_d32", 64'(d32), 64'hABCD);
        sel  = 2'b10;
        inst = 32'd1 << 7;
        pc   = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        chk("pc4_wrap32", 64'(d32), 64'd0);
        chk("pc4_wrap64", d64, 64'd0);
        {rst, stall} = 2'b11;
        cyc();
        chk("rst_in_stall", 64'(v32), 64'd0);
        {rst, stall} = 2'b00;
        for (int i = 0; i < 17; i++) begin
            rnd_in();
            valid = 1'b1;
            cyc();
            rnd_in();
            valid = 1'b0;
            cyc();
        end
        chk("wrap_cnt32", 64'(c32), 64'd1);
        chk("wrap_cnt64", 64'(c64), 64'd17);
        rdata = 64'h8000_0000_1234_5678;
        ld(3'd3, 0); chk("ld64", d64, 64'h8000_0000_1234_5678);
        ld(3'd6, 4); chk("lwu64", d64, 64'h0000_0000_8000_0000);
        ld(3'd2, 4); chk("lw64", d64, 64'hFFFF_FFFF_8000_0000);
        for (int i = 0; i < 300; i++) begin
            rnd_in();
            rst   = $urandom_range(39) == 0;
            flush = $urandom_range(7) == 0;
            stall = $urandom_range(3) == 0;
            if ($urandom_range(1) == 0) sel = 2'b01;
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
